// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : Shared sizing constants for the hazard scoreboard: register count,
//            register address width and pending-counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

   // Architectural register file size and its address width.
   localparam int SB_NUM_REGS        = 16;
   localparam int REG_ADDRESS_LEN    = 4;

   // EX->MEM->WB allows at most 3 writes in flight per register, so 2 bits
   // are enough for each pending counter.
   localparam int SCOREBOARD_CNT_LEN = 2;

   typedef logic [REG_ADDRESS_LEN-1:0] reg_addr_t;

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_pending_counter.sv
`default_nettype none
// ============================================================================
// Module   : pending_counter
// Purpose  : Saturating up/down counter of in-flight writes to one resource.
//            Simultaneous inc and dec cancel. An increment at the maximum or
//            a decrement at zero leaves the count unchanged and pulses
//            ovf / unf for that cycle.
// Ports    : clk, rst (async, active-low)
//            inc, dec          - count events this cycle
//            count             - current registered count
//            nonzero           - count != 0
//            ovf, unf          - combinational overflow / underflow pulses
// Revision : 1.0 - initial release
// ============================================================================
module pending_counter
   import hazard_scoreboard_pkg::*;
#(
   parameter int CNT_W = SCOREBOARD_CNT_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             nonzero,
   output logic             ovf,
   output logic             unf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic inc_only;
   logic dec_only;

   assign inc_only = inc & ~dec;
   assign dec_only = dec & ~inc;

   assign ovf     = inc_only & (count == CNT_MAX);
   assign unf     = dec_only & (count == '0);
   assign nonzero = (count != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc_only && !ovf) begin
         count <= count + 1'b1;
      end else if (dec_only && !unf) begin
         count <= count - 1'b1;
      end
   end

endmodule : pending_counter
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks register and status-flag writes between issue and
//            retirement and raises a combinational stall when the instruction
//            in decode reads something an older instruction has not written.
// Ports    : clk, rst (async, active-low)
//            issue_valid/issue_wb_en/issue_dest/issue_status_we - issued instr
//            src1/src2/two_src/uses_status/ignore_hazard       - decode instr
//            wb_en/wb_addr                                      - retiring write
//            status_commit                                      - status write
//            hazard        - stall request (combinational)
//            pending_mask  - bit i set while register i has writes pending
//            err           - sticky counter overflow/underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = SB_NUM_REGS,
   parameter int CNT_W    = SCOREBOARD_CNT_LEN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   input  logic                       issue_wb_en,
   input  logic [REG_ADDRESS_LEN-1:0] issue_dest,
   input  logic                       issue_status_we,
   input  logic [REG_ADDRESS_LEN-1:0] src1,
   input  logic [REG_ADDRESS_LEN-1:0] src2,
   input  logic                       two_src,
   input  logic                       uses_status,
   input  logic                       ignore_hazard,
   input  logic                       wb_en,
   input  logic [REG_ADDRESS_LEN-1:0] wb_addr,
   input  logic                       status_commit,
   output logic                       hazard,
   output logic [NUM_REGS-1:0]        pending_mask,
   output logic                       err
);

   logic [NUM_REGS-1:0] reg_inc;
   logic [NUM_REGS-1:0] reg_dec;
   logic [NUM_REGS-1:0] reg_nz;
   logic [NUM_REGS-1:0] reg_ovf;
   logic [NUM_REGS-1:0] reg_unf;
   logic [NUM_REGS-1:0] busy;
   logic [CNT_W-1:0]    reg_cnt [NUM_REGS];

   logic                st_inc;
   logic                st_dec;
   logic [CNT_W-1:0]    st_cnt;
   logic                st_nz;
   logic                st_ovf;
   logic                st_unf;
   logic                st_busy;

   logic                src1_busy;
   logic                src2_busy;

   // One counter per register: one-hot decode of issue and write-back
   // addresses, plus the retire bypass. A register whose last pending write
   // retires this cycle is already readable because the register file
   // writes before the decode read completes.
   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
         assign reg_inc[i] = issue_valid & issue_wb_en &
                             (issue_dest == REG_ADDRESS_LEN'(i));
         assign reg_dec[i] = wb_en & (wb_addr == REG_ADDRESS_LEN'(i));

         pending_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (reg_inc[i]),
            .dec     (reg_dec[i]),
            .count   (reg_cnt[i]),
            .nonzero (reg_nz[i]),
            .ovf     (reg_ovf[i]),
            .unf     (reg_unf[i])
         );

         assign busy[i] = reg_nz[i] &
                          ~((reg_cnt[i] == CNT_W'(1)) & reg_dec[i]);
      end
   endgenerate

   // Status-flag counter, with the same last-commit bypass.
   assign st_inc = issue_valid & issue_status_we;
   assign st_dec = status_commit;

   pending_counter #(
      .CNT_W (CNT_W)
   ) u_status_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (st_inc),
      .dec     (st_dec),
      .count   (st_cnt),
      .nonzero (st_nz),
      .ovf     (st_ovf),
      .unf     (st_unf)
   );

   assign st_busy = st_nz & ~((st_cnt == CNT_W'(1)) & st_dec);

   // ignore_hazard masks only the register operands; a conditional branch
   // still has to wait for the flags.
   assign src1_busy = busy[src1];
   assign src2_busy = two_src & busy[src2];
   assign hazard    = (~ignore_hazard & (src1_busy | src2_busy)) |
                      (uses_status & st_busy);

   // Counters are registered, so the nonzero flags are already registered.
   assign pending_mask = reg_nz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if ((|reg_ovf) || (|reg_unf) || st_ovf || st_unf) begin
         err <= 1'b1;
      end
   end

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard. Inputs change
//            1 time unit after the rising edge; outputs are checked mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic        issue_wb_en;
   logic [3:0]  issue_dest;
   logic        issue_status_we;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic        two_src;
   logic        uses_status;
   logic        ignore_hazard;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic        status_commit;
   logic        hazard;
   logic [15:0] pending_mask;
   logic        err;

   int asserts;
   int fails;

   hazard_scoreboard dut (
      .clk             (clk),
      .rst             (rst),
      .issue_valid     (issue_valid),
      .issue_wb_en     (issue_wb_en),
      .issue_dest      (issue_dest),
      .issue_status_we (issue_status_we),
      .src1            (src1),
      .src2            (src2),
      .two_src         (two_src),
      .uses_status     (uses_status),
      .ignore_hazard   (ignore_hazard),
      .wb_en           (wb_en),
      .wb_addr         (wb_addr),
      .status_commit   (status_commit),
      .hazard          (hazard),
      .pending_mask    (pending_mask),
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr_inputs();
      issue_valid     = 1'b0;
      issue_wb_en     = 1'b0;
      issue_dest      = 4'd0;
      issue_status_we = 1'b0;
      src1            = 4'd0;
      src2            = 4'd0;
      two_src         = 1'b0;
      uses_status     = 1'b0;
      ignore_hazard   = 1'b0;
      wb_en           = 1'b0;
      wb_addr         = 4'd0;
      status_commit   = 1'b0;
   endtask

   // Close the current cycle: flag an issue into a stall, then advance.
   task automatic tick();
      asserts++;
      if (issue_valid && hazard) begin
         $display("FAIL issue_during_hazard t=%0t: issue_valid=1 while hazard=%0b, required hazard=0",
                  $time, hazard);
         fails++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic do_issue(input logic [3:0] dest);
      issue_valid = 1'b1;
      issue_wb_en = 1'b1;
      issue_dest  = dest;
   endtask

   task automatic no_issue();
      issue_valid     = 1'b0;
      issue_wb_en     = 1'b0;
      issue_status_we = 1'b0;
   endtask

   task automatic test_reset();
      clr_inputs();
      rst = 1'b0;
      #12;
      asserts++;
      if (pending_mask !== 16'h0 || hazard !== 1'b0 || err !== 1'b0) begin
         $display("FAIL reset_state: mask=%h hazard=%b err=%b, required 0000/0/0",
                  pending_mask, hazard, err);
         fails++;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         src1        = 4'($urandom_range(15));
         src2        = 4'($urandom_range(15));
         two_src     = 1'($urandom_range(1));
         uses_status = 1'($urandom_range(1));
         mid();
         asserts++;
         if (pending_mask !== 16'h0 || hazard !== 1'b0 || err !== 1'b0) begin
            $display("FAIL idle_cycle%0d: mask=%h hazard=%b err=%b, required 0000/0/0",
                     i, pending_mask, hazard, err);
            fails++;
         end
         tick();
      end
      clr_inputs();
   endtask

   task automatic test_raw();
      // cycle 1: issue R3 with R3 already in decode (not yet busy)
      src1 = 4'd3;
      do_issue(4'd3);
      mid();
      asserts++;
      if (hazard !== 1'b0) begin
         $display("FAIL raw_c1_hazard: got %b required 0", hazard); fails++;
      end
      tick();
      no_issue();
      // cycles 2-3: stalled
      for (int c = 2; c <= 3; c++) begin
         mid();
         asserts++;
         if (hazard !== 1'b1 || pending_mask[3] !== 1'b1) begin
            $display("FAIL raw_c%0d: hazard=%b mask3=%b required 1/1",
                     c, hazard, pending_mask[3]);
            fails++;
         end
         tick();
      end
      // cycle 4: write-back bypass
      wb_en   = 1'b1;
      wb_addr = 4'd3;
      mid();
      asserts++;
      if (hazard !== 1'b0 || pending_mask[3] !== 1'b1) begin
         $display("FAIL raw_c4_bypass: hazard=%b mask3=%b required 0/1",
                  hazard, pending_mask[3]);
         fails++;
      end
      tick();
      wb_en = 1'b0;
      mid();
      asserts++;
      if (hazard !== 1'b0 || pending_mask !== 16'h0) begin
         $display("FAIL raw_c5: hazard=%b mask=%h required 0/0000",
                  hazard, pending_mask);
         fails++;
      end
      tick();
      clr_inputs();
   endtask

   task automatic test_two_writers();
      do_issue(4'd5);
      tick();
      do_issue(4'd5);
      tick();
      no_issue();
      src1 = 4'd5;
      mid();
      asserts++;
      if (hazard !== 1'b1 || pending_mask !== 16'h0020) begin
         $display("FAIL two_c3: hazard=%b mask=%h required 1/0020", hazard, pending_mask);
         fails++;
      end
      tick();
      // cycle 4: first retire, count 2 -> 1, no bypass
      wb_en   = 1'b1;
      wb_addr = 4'd5;
      mid();
      asserts++;
      if (hazard !== 1'b1) begin
         $display("FAIL two_c4_hazard: got %b required 1", hazard); fails++;
      end
      tick();
      // cycle 5: second retire, count 1 -> 0 with bypass
      mid();
      asserts++;
      if (hazard !== 1'b0 || pending_mask[5] !== 1'b1) begin
         $display("FAIL two_c5: hazard=%b mask5=%b required 0/1", hazard, pending_mask[5]);
         fails++;
      end
      tick();
      wb_en = 1'b0;
      mid();
      asserts++;
      if (pending_mask !== 16'h0 || hazard !== 1'b0 || err !== 1'b0) begin
         $display("FAIL two_c6: mask=%h hazard=%b err=%b required 0000/0/0",
                  pending_mask, hazard, err);
         fails++;
      end
      tick();
      clr_inputs();
   endtask

   task automatic test_simultaneous();
      do_issue(4'd7);
      tick();
      // issue and retire R7 together with count 1
      do_issue(4'd7);
      wb_en   = 1'b1;
      wb_addr = 4'd7;
      tick();
      no_issue();
      wb_en = 1'b0;
      src1  = 4'd7;
      mid();
      asserts++;
      if (hazard !== 1'b1 || pending_mask !== 16'h0080 || err !== 1'b0) begin
         $display("FAIL simul_after: hazard=%b mask=%h err=%b required 1/0080/0",
                  hazard, pending_mask, err);
         fails++;
      end
      tick();
      wb_en   = 1'b1;
      wb_addr = 4'd7;
      mid();
      asserts++;
      if (hazard !== 1'b0) begin
         $display("FAIL simul_drain_bypass: hazard=%b required 0", hazard); fails++;
      end
      tick();
      wb_en = 1'b0;
      mid();
      asserts++;
      if (pending_mask !== 16'h0) begin
         $display("FAIL simul_drained: mask=%h required 0000", pending_mask); fails++;
      end
      tick();
      clr_inputs();
   endtask

   task automatic test_src2_mask();
      do_issue(4'd2);
      tick();
      no_issue();
      src1    = 4'd0;
      src2    = 4'd2;
      two_src = 1'b0;
      mid();
      asserts++;
      if (hazard !== 1'b0) begin
         $display("FAIL src2_single_operand: hazard=%b required 0", hazard); fails++;
      end
      two_src = 1'b1;
      #1;
      asserts++;
      if (hazard !== 1'b1) begin
         $display("FAIL src2_two_operand: hazard=%b required 1", hazard); fails++;
      end
      ignore_hazard = 1'b1;
      #1;
      asserts++;
      if (hazard !== 1'b0) begin
         $display("FAIL src2_ignore: hazard=%b required 0", hazard); fails++;
      end
      tick();
      ignore_hazard = 1'b0;
      wb_en         = 1'b1;
      wb_addr       = 4'd2;
      tick();
      clr_inputs();
      mid();
      asserts++;
      if (pending_mask !== 16'h0) begin
         $display("FAIL src2_drained: mask=%h required 0000", pending_mask); fails++;
      end
      tick();
   endtask

   task automatic test_status();
      issue_valid     = 1'b1;
      issue_status_we = 1'b1;
      mid();
      asserts++;
      if (hazard !== 1'b0) begin
         $display("FAIL status_c1: hazard=%b required 0", hazard); fails++;
      end
      tick();
      no_issue();
      uses_status   = 1'b1;
      ignore_hazard = 1'b1;
      for (int c = 2; c <= 3; c++) begin
         mid();
         asserts++;
         if (hazard !== 1'b1) begin
            $display("FAIL status_c%0d_pending: hazard=%b required 1", c, hazard); fails++;
         end
         tick();
      end
      status_commit = 1'b1;
      mid();
      asserts++;
      if (hazard !== 1'b0) begin
         $display("FAIL status_commit_bypass: hazard=%b required 0", hazard); fails++;
      end
      tick();
      status_commit = 1'b0;
      mid();
      asserts++;
      if (hazard !== 1'b0 || err !== 1'b0) begin
         $display("FAIL status_cleared: hazard=%b err=%b required 0/0", hazard, err);
         fails++;
      end
      tick();
      clr_inputs();
   endtask

   task automatic test_err();
      wb_en   = 1'b1;
      wb_addr = 4'd9;
      mid();
      asserts++;
      if (err !== 1'b0) begin
         $display("FAIL err_before_edge: err=%b required 0", err); fails++;
      end
      tick();
      wb_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         mid();
         asserts++;
         if (err !== 1'b1 || pending_mask !== 16'h0) begin
            $display("FAIL err_sticky%0d: err=%b mask=%h required 1/0000", c, err, pending_mask);
            fails++;
         end
         tick();
      end
      clr_inputs();
   endtask

   task automatic test_mid_reset();
      do_issue(4'd4);
      issue_status_we = 1'b1;
      tick();
      no_issue();
      src1        = 4'd4;
      uses_status = 1'b1;
      mid();
      asserts++;
      if (hazard !== 1'b1 || pending_mask !== 16'h0010 || err !== 1'b1) begin
         $display("FAIL midrst_before: hazard=%b mask=%h err=%b required 1/0010/1",
                  hazard, pending_mask, err);
         fails++;
      end
      rst = 1'b0;
      #1;
      asserts++;
      if (hazard !== 1'b0 || pending_mask !== 16'h0 || err !== 1'b0) begin
         $display("FAIL midrst_async: hazard=%b mask=%h err=%b required 0/0000/0",
                  hazard, pending_mask, err);
         fails++;
      end
      tick();
      rst = 1'b1;
      mid();
      asserts++;
      if (hazard !== 1'b0 || pending_mask !== 16'h0 || err !== 1'b0) begin
         $display("FAIL midrst_after: hazard=%b mask=%h err=%b required 0/0000/0",
                  hazard, pending_mask, err);
         fails++;
      end
      tick();
      clr_inputs();
   endtask

   initial begin
      asserts = 0;
      fails   = 0;
      rst     = 1'b0;
      clr_inputs();
      test_reset();
      test_raw();
      test_two_writers();
      test_simultaneous();
      test_src2_mask();
      test_status();
      test_err();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule : tb_hazard_scoreboard
`default_nettype wire
